idct_8x8_engine: RTL and testbench

Inverse 2-D DCT engine for 8×8 blocks; the decode-side counterpart of the forward DCT datapath.
- Accepts 64 signed DCT coefficients over a valid/ready stream and stores them in a coefficient buffer.
- Reconstructs each pixel with one multiply-accumulate per cycle, using the same orthonormal Q10 basis values as the forward cosine tables.
- Emits 64 level-shifted, saturated 8-bit pixels over a second valid/ready stream.

---
 rtl/idct_pkg.sv | 30 +++
 rtl/idct_8x8_engine_if.sv | 24 ++
 rtl/idct_basis_lut.sv | 23 ++
 rtl/idct_8x8_engine.sv | 115 +++++++++++
 tb/tb_idct_8x8_engine.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/idct_pkg.sv
// Shared types and constants for the 8x8 inverse DCT engine.
// T holds orthonormal Q10 cosine basis values, T[k][n].
package idct_pkg;

  localparam int COEF_W      = 16;
  localparam int ACC_W       = 40;
  localparam int B_W         = 12;
  localparam int PROD_W      = COEF_W + B_W;
  localparam int LEVEL_SHIFT = 128;
  localparam int Q10         = 10;
  localparam int RND         = 512;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUT
  } state_e;

  localparam int T [8][8] = '{
    '{ 362,  362,  362,  362,  362,  362,  362,  362},
    '{ 502,  426,  284,  100, -100, -284, -426, -502},
    '{ 473,  196, -196, -473, -473, -196,  196,  473},
    '{ 426, -100, -502, -284,  284,  502,  100, -426},
    '{ 362, -362, -362,  362,  362, -362, -362,  362},
    '{ 284, -502,  100,  426, -426, -100,  502, -284},
    '{ 196, -473,  473, -196, -196,  473, -473,  196},
    '{ 100, -284,  426, -502,  502, -426,  284, -100}
  };

endpackage

// File: rtl/idct_8x8_engine_if.sv
// Coefficient-in / pixel-out valid/ready streams of the IDCT engine.
// master = producer/consumer side, slave = engine side.
interface idct_8x8_engine_if;
  import idct_pkg::*;

  logic                     coef_valid;
  logic                     coef_ready;
  logic signed [COEF_W-1:0] coef_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [7:0]               pix_data;
  logic                     block_done;

  modport master (
    output coef_valid, coef_data, pix_ready,
    input  coef_ready, pix_valid, pix_data, block_done
  );

  modport slave (
    input  coef_valid, coef_data, pix_ready,
    output coef_ready, pix_valid, pix_data, block_done
  );

endinterface

// File: rtl/idct_basis_lut.sv
// Combinational 2-D basis: B = round_half_up(T[k1][n1]*T[k2][n2] / 1024).
// Result fits a signed 12-bit Q10 value.
module idct_basis_lut
  import idct_pkg::*;
(
  input  logic [2:0]            k1_i,
  input  logic [2:0]            k2_i,
  input  logic [2:0]            n1_i,
  input  logic [2:0]            n2_i,
  output logic signed [B_W-1:0] b_o
);

  int prod;
  int rnd;

  always_comb begin
    prod = T[k1_i][n1_i] * T[k2_i][n2_i];
    rnd  = (prod + RND) >>> Q10;
  end

  assign b_o = B_W'(rnd);

endmodule

// File: rtl/idct_8x8_engine.sv
// 8x8 inverse DCT: buffer 64 coefficients, one MAC per cycle per pixel,
// emit level-shifted, clamped 8-bit pixels.
module idct_8x8_engine
  import idct_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  idct_8x8_engine_if.slave bus
);

  state_e                   state_q;
  logic [5:0]               cnt_q;
  logic [5:0]               k_q;
  logic [5:0]               p_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [7:0]               pix_q;
  logic                     done_q;
  logic signed [COEF_W-1:0] buf_q [64];

  logic signed [B_W-1:0]    b;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] coef_x;
  logic signed [PROD_W-1:0] b_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum_d;
  logic                     coef_hs;

  idct_basis_lut u_lut (
    .k1_i (k_q[5:3]),
    .k2_i (k_q[2:0]),
    .n1_i (p_q[5:3]),
    .n2_i (p_q[2:0]),
    .b_o  (b)
  );

  assign coef   = buf_q[k_q];
  assign coef_x = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};
  assign b_x    = {{(PROD_W-B_W){b[B_W-1]}}, b};
  assign prod   = coef_x * b_x;
  assign sum_d  = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  assign coef_hs = (state_q == LOAD) && bus.coef_valid;

  assign bus.coef_ready = (state_q == LOAD);
  assign bus.pix_valid  = (state_q == OUT);
  assign bus.pix_data   = pix_q;
  assign bus.block_done = done_q;

  function automatic logic [7:0] clamp(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [7:0]              r;
    s = ((a + ACC_W'(RND)) >>> Q10) + ACC_W'(LEVEL_SHIFT);
    if (s < 0)        r = 8'd0;
    else if (s > 255) r = 8'd255;
    else              r = 8'(s);
    return r;
  endfunction

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (coef_hs) buf_q[cnt_q] <= bus.coef_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      k_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      pix_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        (state_q == LOAD): begin
          if (coef_hs) begin
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
              state_q <= COMPUTE;
              acc_q   <= '0;
              k_q     <= '0;
              p_q     <= '0;
            end
          end
        end
        (state_q == COMPUTE): begin
          k_q <= k_q + 6'd1;
          if (k_q == 6'd63) begin
            pix_q   <= clamp(sum_d);
            state_q <= OUT;
          end else begin
            acc_q <= sum_d;
          end
        end
        (state_q == OUT): begin
          if (bus.pix_ready) begin
            if (p_q == 6'd63) begin
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= LOAD;
            end else begin
              p_q     <= p_q + 6'd1;
              acc_q   <= '0;
              k_q     <= '0;
              state_q <= COMPUTE;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_8x8_engine.sv
// Bench for idct_8x8_engine: directed table, random blocks against a
// real-valued cosine reference, backpressure and mid-block reset.
module tb_idct_8x8_engine;
  import idct_pkg::*;

  localparam real PI = 3.141592653589793;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  idct_8x8_engine_if bus ();

  idct_8x8_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bd_cnt = 0;
  int hs_cyc = 0;
  int bd0 = 0;
  bit gaps = 0;
  int coefs [64];
  int expv [64];
  int got [64];
  int bas [64][64];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.block_done) bd_cnt <= bd_cnt + 1;

  typedef struct {
    int idx;
    int val;
    int p0;
    int p1;
    bit uniform;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int tval(input int k, input int n);
    real a;
    real x;
    a = (k == 0) ? $sqrt(0.125) : 0.5;
    x = a * $cos(real'((2 * n + 1) * k) * PI / 16.0) * 1024.0;
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic void build_basis();
    real q;
    for (int k = 0; k < 64; k++)
      for (int p = 0; p < 64; p++) begin
        q = real'(tval(k / 8, p / 8) * tval(k % 8, p % 8)) / 1024.0;
        bas[k][p] = $rtoi($floor(q + 0.5));
      end
  endfunction

  function automatic void ref_block();
    longint acc;
    int s;
    for (int p = 0; p < 64; p++) begin
      acc = 0;
      for (int k = 0; k < 64; k++)
        acc += longint'(coefs[k]) * longint'(bas[k][p]);
      s = $rtoi($floor(real'(acc + 512) / 1024.0)) + LEVEL_SHIFT;
      expv[p] = (s < 0) ? 0 : (s > 255) ? 255 : s;
    end
  endfunction

  task automatic load_block();
    int i = 0;
    int g = 0;
    while (i < 64 && g < 2000) begin
      @(negedge clk);
      g++;
      bus.coef_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.coef_data  = 16'(coefs[i]);
      if (bus.coef_valid && bus.coef_ready) begin
        i++;
        if (i == 64) hs_cyc = cyc + 1;
      end
    end
    chk("load_count", i, 64);
  endtask

  task automatic collect(input int npix, input int stall_at);
    int idx = 0;
    int g = 0;
    int st = 0;
    logic [7:0] hold = '0;
    bit first = 1'b1;
    bus.pix_ready = 1'b1;
    while (idx < npix && g < 6000) begin
      @(negedge clk);
      g++;
      // Producer keeps pushing junk; the engine must ignore it.
      bus.coef_valid = 1'b1;
      bus.coef_data  = 16'sh7abc;
      if (idx == stall_at && st > 0 && st < 11) begin
        chk("stall_valid", bus.pix_valid, 1);
        chk("stall_data", bus.pix_data, hold);
      end
      if (bus.pix_valid) begin
        if (first) begin
          chk("first_latency", cyc - hs_cyc, 64);
          chk("coef_ready_busy", bus.coef_ready, 0);
          first = 1'b0;
        end
        if (idx == stall_at && st < 10) begin
          if (st == 0) hold = bus.pix_data;
          bus.pix_ready = 1'b0;
          st++;
        end else begin
          bus.pix_ready = 1'b1;
          got[idx] = int'(bus.pix_data);
          chk($sformatf("pix%0d", idx), bus.pix_data, expv[idx]);
          idx++;
        end
      end
    end
    bus.coef_valid = 1'b0;
    if (idx < npix) chk("pix_timeout", idx, npix);
  endtask

  task automatic run_block(input int stall_at);
    bd0 = bd_cnt;
    load_block();
    collect(64, stall_at);
    @(negedge clk);
    chk("block_done_hi", bus.block_done, 1);
    chk("coef_ready_done", bus.coef_ready, 1);
    chk("pix_valid_done", bus.pix_valid, 0);
    @(negedge clk);
    chk("block_done_lo", bus.block_done, 0);
    chk("block_done_pulses", bd_cnt - bd0, 1);
  endtask

  initial begin
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    bus.pix_ready  = 1'b0;
    build_basis();

    tbl[0] = '{0, 0, 128, 128, 1'b1};
    tbl[1] = '{0, 80, 138, 138, 1'b1};
    tbl[2] = '{0, 8000, 255, 255, 1'b1};
    tbl[3] = '{0, -8000, 0, 0, 1'b1};
    tbl[4] = '{14, 1024, 224, 0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_coef_ready", bus.coef_ready, 1);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_pix_data", bus.pix_data, 0);
    chk("rst_block_done", bus.block_done, 0);

    foreach (tbl[t]) begin
      foreach (coefs[i]) coefs[i] = 0;
      coefs[tbl[t].idx] = tbl[t].val;
      if (tbl[t].uniform) foreach (expv[i]) expv[i] = tbl[t].p0;
      else ref_block();
      run_block(-1);
      if (!tbl[t].uniform) begin
        chk("ac_pix00", got[0], tbl[t].p0);
        chk("ac_pix01", got[1], tbl[t].p1);
      end
    end

    gaps = 1'b1;
    for (int r = 0; r < 3; r++) begin
      foreach (coefs[i])
        coefs[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 400)) - 200 : 0;
      coefs[0] = int'($urandom_range(0, 3000)) - 1500;
      ref_block();
      run_block(r == 0 ? 20 : -1);
    end
    gaps = 1'b0;

    // Reset while pixel 5 is being accumulated.
    foreach (coefs[i]) coefs[i] = 0;
    coefs[0] = 80;
    foreach (expv[i]) expv[i] = 138;
    bd0 = bd_cnt;
    load_block();
    collect(5, -1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_coef_ready", bus.coef_ready, 1);
    chk("midrst_pix_valid", bus.pix_valid, 0);
    chk("midrst_pix_data", bus.pix_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_no_done", bd_cnt - bd0, 0);
    run_block(-1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
